// File: rtl/seg_pkg.sv
// Shared constants for 7-segment readback: legal active-low codes (gfedcba), blank, FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/seg_to_nibble.sv
// Combinational inverse of the hex display decoder: pattern -> {illegal, nibble}.
// Zero latency; no handshake. Illegal patterns report nibble 0.
module seg_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       illegal_o
);

  always_comb begin
    nibble_o  = 4'h0;
    illegal_o = 1'b0;
    case (seg_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Debounces a 7-segment bus and emits each newly stable pattern as a nibble over valid/ready.
// Latency 1+STABLE_CYCLES; a pending value is overwritten (and overrun flagged) if the consumer stalls.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_nibble,
  output logic       out_error,
  output logic [7:0] err_count,
  output logic       overrun
);
  import seg_pkg::*;

  localparam logic [7:0] THRESH      = 8'(STABLE_CYCLES);
  localparam logic [7:0] THRESH_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] samp_q, cand_q, last_q;
  logic [7:0] cnt_q, cnt_d;
  logic       last_vld_q;
  state_t     state_q, state_d;
  logic [3:0] nib_q, nib_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       ovr_q, ovr_d;

  logic       match, stable, accept;
  logic [3:0] dec_nib;
  logic       dec_illegal;

  seg_to_nibble u_dec (
    .seg_i     (samp_q),
    .nibble_o  (dec_nib),
    .illegal_o (dec_illegal)
  );

  // cnt saturates, so the threshold crossing (and thus stable) fires once per run
  assign match  = (samp_q == cand_q);
  assign stable = match && (cnt_q == THRESH_LAST);
  assign accept = stable && (!last_vld_q || (samp_q != last_q));

  always_comb begin
    cnt_d = 8'd1;
    if (match) cnt_d = (cnt_q == THRESH) ? cnt_q : cnt_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    nib_d     = nib_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = PEND;
      end
      PEND: begin
        if (accept) begin
          if (!out_ready) ovr_d = 1'b1;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      nib_d = dec_illegal ? 4'h0 : dec_nib;
      err_d = dec_illegal;
      if (dec_illegal && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      samp_q     <= SEG_BLANK;
      cand_q     <= SEG_BLANK;
      cnt_q      <= 8'd0;
      last_q     <= SEG_BLANK;
      last_vld_q <= 1'b0;
      state_q    <= IDLE;
      nib_q      <= 4'h0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
      ovr_q      <= 1'b0;
    end else begin
      samp_q    <= seg_in;
      cand_q    <= samp_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      nib_q     <= nib_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      ovr_q     <= ovr_d;
      if (accept) begin
        last_q     <= samp_q;
        last_vld_q <= 1'b1;
      end
    end
  end

  assign out_valid  = (state_q == PEND);
  assign out_nibble = nib_q;
  assign out_error  = err_q;
  assign err_count  = err_cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/seg_capture.md
# seg_capture

Recovers 4-bit values from the active-low 7-segment patterns produced by the team's hex display decoders. The block samples a `seg_in` bus, filters out glitches with a stability counter, decodes each stable pattern back to a nibble, and emits each new value once through a valid/ready handshake. It sits on the display side of the ALU/register datapath and lets a bench or on-chip checker read back what `HEX0`/`HEX4`/`HEX5` show.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted; legal range 2–255.
- `clock` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `seg_in` input, 7 bits: segment pattern, bit0 = a … bit6 = g, active-low (0 = lit).
- `out_ready` input, 1 bit: consumer accepts `out_nibble` when high together with `out_valid`.
- `out_valid` output, 1 bit: `out_nibble`/`out_error` hold a new accepted value.
- `out_nibble` output, 4 bits: decoded value; 0 when `out_error` = 1.
- `out_error` output, 1 bit: the accepted pattern is not one of the 16 legal codes.
- `err_count` output, 8 bits: saturating count of accepted illegal patterns.
- `overrun` output, 1 bit: sticky flag; a new value became stable while the previous one was still pending.

## Operation
- Legal codes (gfedcba, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E. Any other value is illegal.
- Stability filter:
  - `seg_in` is registered once into `samp`.
  - `cand` holds the candidate pattern; `cnt` is 8 bits.
  - If `samp != cand`: `cand <= samp`, `cnt <= 1`.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES`.
  - A pattern becomes stable on the cycle `cnt` reaches `STABLE_CYCLES`.
- Change detection:
  - `last` holds the most recently accepted pattern, plus a `last_vld` bit.
  - A stable pattern is accepted only if `!last_vld` or it differs from `last`.
  - A held pattern is therefore emitted once.
- FSM states:
  - IDLE: no value pending.
    - On acceptance: load `out_nibble`/`out_error`, update `last`, go to PEND.
  - PEND: `out_valid` = 1.
    - On `out_ready`: go to IDLE.
    - If a new acceptance occurs in the same cycle as the handshake: load the new value and stay in PEND; `overrun` is not set.
    - If a new acceptance occurs without `out_ready`: overwrite the output registers (newest value wins), set `overrun`.
- On each acceptance of an illegal code, `err_count` increments and saturates at 255.
- Reset values:
  - `out_valid` = 0, `out_nibble` = 0, `out_error` = 0, `err_count` = 0, `overrun` = 0.
  - `samp` = `cand` = 7'h7F (blank), `cnt` = 0, `last_vld` = 0, state IDLE.
- Blank (7F) is an illegal code like any other and is counted if it becomes stable.
- Reset takes priority over every other event. A reset mid-settle or in PEND discards pending data with no handshake.

## Timing
- Latency: `seg_in` stable from cycle t → `out_valid` high at rising edge t+1+`STABLE_CYCLES`. One cycle is for `samp`; `cnt` reaches the threshold after `STABLE_CYCLES` matches.
- `out_valid` is registered. Once asserted it holds until the handshake cycle, and the data stays stable except on overrun.
- Handshake completes on any edge with `out_valid` & `out_ready`. `out_valid` drops the next cycle unless there is a simultaneous acceptance.
- `out_ready` may be held high permanently.
- Any single-cycle glitch restarts the count, so no value is emitted for glitches shorter than `STABLE_CYCLES`.

## Structure
- Shared package `seg_pkg`:
  - the 16 legal code constants;
  - the blank constant 7'h7F;
  - the FSM state enum (IDLE, PEND).
- One natural sub-module, `seg_to_nibble`: combinational lookup from 7-bit pattern to {illegal, nibble}. Its codes are the exact inverse of the team's hex decoder.
- Top level holds the filter, change detector, FSM and counters.

## Test plan
- Sweep: after reset, drive each of the 16 legal codes for 6 cycles with `out_ready` = 1 → 16 handshakes with nibbles 0..F in order, `out_error` = 0, `err_count` = 0.
- Glitch: hold 30 (3), insert one cycle of 79, then 30 again, `STABLE_CYCLES` = 4 → exactly one output, nibble 3; no nibble 1 emitted.
- Backpressure/overrun: `out_ready` = 0; stabilise 12 (5), then 03 (b) → `out_valid` stays 1, `out_nibble` = B, `overrun` = 1; a later `out_ready` pulse completes one handshake with value B.
- Illegal: stabilise 7F, then 55, then 40 → two error outputs (`out_error` = 1, nibble 0), `err_count` = 2, then nibble 0 with `out_error` = 0.
- Repeat suppression: hold 18 (9) for 50 cycles → one output, nibble 9. Change to 00 and back to 18 → outputs 8 then 9.
- Reset mid-operation: assert `reset` for one cycle while in PEND with nibble 7 pending → the next cycle shows `out_valid` = 0 and all outputs zeroed. The same stable 78 is then re-emitted as 7 after 1+`STABLE_CYCLES` cycles.
